// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with frame-based debounce
// Optional auto-repeat of a held key: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_SCANS   = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [1:0] count,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [1:0] F_NONE   = 2'd0;
  localparam logic [1:0] F_SINGLE = 2'd1;
  localparam logic [1:0] F_MULTI  = 2'd2;

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  logic             started_q, started_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       count_q, count_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [1:0]       acc_n_q, acc_n_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic             frame_valid_q, frame_valid_d;
  logic [1:0]       frame_kind_q, frame_kind_d;
  logic [3:0]       frame_code_q, frame_code_d;

  logic       sample;
  logic [2:0] col_n;
  logic [3:0] col_code;
  logic [1:0] base_n;
  logic [2:0] tot_n;
  logic [1:0] merged_kind;
  logic [3:0] merged_code;
  logic [1:0] next_count;

  always_comb begin
    sample   = started_q && (div_q == DIV_LAST);
    col_n    = 3'd0;
    col_code = 4'h0;
    // descending loop so the lowest pressed row supplies the code
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2_q[r]) begin
        col_n    = col_n + 3'd1;
        col_code = key_map(2'(r), count_q);
      end
    end
    base_n      = (count_q == 2'd0) ? 2'd0 : acc_n_q;
    tot_n       = {1'b0, base_n} + col_n;
    merged_kind = (tot_n >= 3'd2) ? F_MULTI : tot_n[1:0];
    merged_code = (base_n != 2'd0) ? acc_code_q : col_code;
    next_count  = count_q + 2'd1;

    started_d     = 1'b1;
    div_d         = div_q;
    count_d       = count_q;
    col_d         = col_q;
    acc_n_d       = acc_n_q;
    acc_code_d    = acc_code_q;
    frame_valid_d = 1'b0;
    frame_kind_d  = frame_kind_q;
    frame_code_d  = frame_code_q;

    if (!started_q) begin
      col_d = 4'b1110;
    end else if (sample) begin
      div_d      = '0;
      count_d    = next_count;
      col_d      = ~(4'b0001 << next_count);
      acc_n_d    = merged_kind;
      acc_code_d = merged_code;
      if (count_q == 2'd3) begin
        frame_valid_d = 1'b1;
        frame_kind_d  = merged_kind;
        frame_code_d  = merged_code;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      started_q     <= 1'b0;
      div_q         <= '0;
      count_q       <= 2'd0;
      col_q         <= 4'b1111;
      row_s1_q      <= 4'b1111;
      row_s2_q      <= 4'b1111;
      acc_n_q       <= 2'd0;
      acc_code_q    <= 4'h0;
      frame_valid_q <= 1'b0;
      frame_kind_q  <= F_NONE;
      frame_code_q  <= 4'h0;
    end else begin
      started_q     <= started_d;
      div_q         <= div_d;
      count_q       <= count_d;
      col_q         <= col_d;
      row_s1_q      <= row;
      row_s2_q      <= row_s1_q;
      acc_n_q       <= acc_n_d;
      acc_code_q    <= acc_code_d;
      frame_valid_q <= frame_valid_d;
      frame_kind_q  <= frame_kind_d;
      frame_code_q  <= frame_code_d;
    end
  end

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  state_t           state_q;
  logic [DEB_W-1:0] deb_q;
  logic [DEB_W-1:0] deb_inc;
  logic [3:0]       cand_q;
  logic [3:0]       code_q;
  logic             valid_q;
  logic             held_q;

  assign deb_inc = deb_q + DEB_ONE;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_inc;
  assign rep_inc = rep_q + REP_W'(1);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      deb_q   <= '0;
      cand_q  <= 4'h0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (frame_valid_q) begin
        case (state_q)
          IDLE: begin
            if (frame_kind_q == F_SINGLE) begin
              cand_q <= frame_code_q;
              if (DEBOUNCE_SCANS == 1) begin
                code_q  <= frame_code_q;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                deb_q   <= '0;
                state_q <= HELD;
              end else begin
                deb_q   <= DEB_ONE;
                state_q <= PRESS;
              end
            end
          end
          PRESS: begin
            if (frame_kind_q != F_SINGLE) begin
              deb_q   <= '0;
              state_q <= IDLE;
            end else if (frame_code_q != cand_q) begin
              cand_q <= frame_code_q;
              deb_q  <= DEB_ONE;
            end else if (deb_inc == DEB_MAX) begin
              code_q  <= cand_q;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              deb_q   <= '0;
              state_q <= HELD;
            end else begin
              deb_q <= deb_inc;
            end
          end
          HELD: begin
            // extra keys while held are absorbed; only a clean release leaves
            if (frame_kind_q == F_NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                held_q  <= 1'b0;
                deb_q   <= '0;
                state_q <= IDLE;
              end else begin
                deb_q   <= DEB_ONE;
                state_q <= RELEASE;
              end
            end else begin
              deb_q <= '0;
            end
          end
          RELEASE: begin
            if (frame_kind_q != F_NONE) begin
              deb_q   <= '0;
              state_q <= HELD;
            end else if (deb_inc == DEB_MAX) begin
              held_q  <= 1'b0;
              deb_q   <= '0;
              state_q <= IDLE;
            end else begin
              deb_q <= deb_inc;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
`ifdef KEYPAD_REPEAT_EN
      if (state_q != HELD) begin
        rep_q <= '0;
      end else if (frame_valid_q) begin
        if (frame_kind_q == F_SINGLE && frame_code_q == code_q) begin
          if (rep_inc == REP_W'(REPEAT_DELAY)) begin
            valid_q <= 1'b1;
            rep_q   <= rep_inc;
          end else if (rep_inc == REP_W'(REPEAT_DELAY + REPEAT_SCANS)) begin
            valid_q <= 1'b1;
            rep_q   <= REP_W'(REPEAT_DELAY);
          end else begin
            rep_q <= rep_inc;
          end
        end else begin
          rep_q <= '0;
        end
      end
`endif
    end
  end

  assign col       = col_q;
  assign count     = count_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_SCANS=3)
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [1:0]  count;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;
  int npulse;
  int pidx;
  int viol = 0;
  logic [3:0] pcode;
  logic       prev_valid = 1'b0;
  logic [3:0] exp_col;

  keypad_scanner #(
    .SCAN_DIV(8),
    .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(2),
    .REPEAT_SCANS(1)
  ) dut (
    .clock(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .count(count),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // pressed[r*4+c] shorts row r to column c
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(pressed[r*4 +: 4] & ~col)) row[r] = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frames(input int n);
    npulse = 0;
    pidx   = -1;
    pcode  = 4'h0;
    for (int i = 0; i < n * 32; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        if (prev_valid) viol++;
        npulse++;
        pidx  = i;
        pcode = key_code;
      end
      prev_valid = key_valid;
    end
  endtask

  initial begin
    reset   = 1'b1;
    pressed = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col",   32'(col), 32'hF);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_code",  32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held",  32'(key_held), 32'h0);

    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << (i / 8));
      chk("scan_col", 32'(col), 32'(exp_col));
      chk("scan_count", 32'(count), 32'(i / 8));
    end
    run_frames(3);
    chk("idle_pulses", 32'(npulse), 32'd0);

    // key '5': row1, col1
    pressed = 16'h0020;
    run_frames(3);
    chk("k5_early", 32'(npulse), 32'd0);
    run_frames(1);
    chk("k5_pulses", 32'(npulse), 32'd1);
    chk("k5_idx",    32'(pidx), 32'd1);
    chk("k5_code",   32'(pcode), 32'h5);
    chk("k5_held",   32'(key_held), 32'd1);
    pressed = 16'h0;
    run_frames(3);
    chk("k5_rel_pulses", 32'(npulse), 32'd0);
    chk("k5_rel_held",   32'(key_held), 32'd1);
    run_frames(1);
    chk("k5_rel_done",   32'(key_held), 32'd0);
    chk("k5_rel_none",   32'(npulse), 32'd0);
    chk("k5_code_kept",  32'(key_code), 32'h5);

    // key 'D' bouncing: row3, col3
    pressed = 16'h8000;
    run_frames(2);
    chk("kd_b1", 32'(npulse), 32'd0);
    pressed = 16'h0;
    run_frames(1);
    chk("kd_b2", 32'(npulse), 32'd0);
    pressed = 16'h8000;
    run_frames(3);
    chk("kd_b3", 32'(npulse), 32'd0);
    run_frames(1);
    chk("kd_pulses", 32'(npulse), 32'd1);
    chk("kd_code",   32'(pcode), 32'hD);
    pressed = 16'h0;
    run_frames(4);
    chk("kd_rel_held", 32'(key_held), 32'd0);

    // hold '1', add '2', drop '2'
    pressed = 16'h0001;
    run_frames(4);
    chk("k1_pulses", 32'(npulse), 32'd1);
    chk("k1_code",   32'(pcode), 32'h1);
    pressed = 16'h0003;
    run_frames(5);
    chk("k12_pulses", 32'(npulse), 32'd0);
    chk("k12_held",   32'(key_held), 32'd1);
    pressed = 16'h0001;
    run_frames(3);
    chk("k1b_pulses", 32'(npulse), 32'd0);
    chk("k1b_held",   32'(key_held), 32'd1);
    chk("k1b_code",   32'(key_code), 32'h1);
    pressed = 16'h0;
    run_frames(4);
    chk("k1_rel_held", 32'(key_held), 32'd0);

    // key 'A' held past acceptance: row0, col3
    pressed = 16'h0008;
    run_frames(4);
    chk("ka_pulses", 32'(npulse), 32'd1);
    chk("ka_code",   32'(pcode), 32'hA);
    run_frames(6);
`ifdef KEYPAD_REPEAT_EN
    chk("ka_repeats", 32'(npulse), 32'd5);
    chk("ka_rep_code", 32'(pcode), 32'hA);
`else
    chk("ka_no_repeat", 32'(npulse), 32'd0);
`endif
    pressed = 16'h0;
    run_frames(4);
    chk("ka_rel_held", 32'(key_held), 32'd0);

    // key '8' (row2, col1) interrupted by reset while debouncing
    pressed = 16'h0200;
    run_frames(2);
    chk("k8_pre", 32'(npulse), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("k8_prereset_valid", 32'(key_valid), 32'd0);
    reset   = 1'b1;
    pressed = 16'h0;
    @(posedge clk);
    #1;
    chk("mid_rst_col",   32'(col), 32'hF);
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_code",  32'(key_code), 32'h0);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_held",  32'(key_held), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_frames(4);
    chk("k8_after_pulses", 32'(npulse), 32'd0);
    chk("k8_after_held",   32'(key_held), 32'd0);
    chk("k8_after_code",   32'(key_code), 32'h0);

    chk("no_back_to_back", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
